// File: rtl/robo_seguidor_param.sv
// Wall-following controller for the grid robot: one decision per passo strobe,
// registered action pulses, saturating move counter and stuck detection.
module robo_seguidor_param #(
  parameter int CNT_W     = 8,
  parameter int MAX_GIROS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             passo,
  input  logic             head,
  input  logic             left,
  input  logic             right,
  input  logic             lado,
  output logic             avancar,
  output logic             girar,
  output logic             girar_dir,
  output logic             travado,
  output logic [1:0]       estado,
  output logic [CNT_W-1:0] movimentos
);

  typedef enum logic [1:0] {
    BUSCA    = 2'b00,
    SEGUE    = 2'b01,
    CONTORNA = 2'b10,
    TRAVADO  = 2'b11
  } state_t;

  localparam int               GW        = $clog2(MAX_GIROS + 1);
  localparam logic [GW-1:0]    GIROS_LIM = GW'(MAX_GIROS);
  localparam logic [CNT_W-1:0] MOV_MAX   = '1;

  state_t           state_q, state_d;
  logic [GW-1:0]    giros_q, giros_d;
  logic [CNT_W-1:0] mov_q, mov_d;
  logic             avancar_q, avancar_d;
  logic             girar_q, girar_d;
  logic             girar_dir_q, girar_dir_d;
  logic             travado_q, travado_d;

  logic w, do_adv, do_turn, turn_dir;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    state_d   = state_q;
    giros_d   = giros_q;
    mov_d     = mov_q;
    travado_d = travado_q;
    do_adv    = 1'b0;
    do_turn   = 1'b0;
    turn_dir  = 1'b0;
    w         = lado ? right : left;

    if (passo) begin
      case (state_q)
        BUSCA: begin
          if (head) begin
            do_turn  = 1'b1;
            turn_dir = !lado;
            state_d  = SEGUE;
          end else begin
            do_adv = 1'b1;
            if (w) state_d = SEGUE;
          end
        end
        SEGUE: begin
          if (!w) begin
            do_turn  = 1'b1;
            turn_dir = lado;
            state_d  = CONTORNA;
          end else if (head) begin
            do_turn  = 1'b1;
            turn_dir = !lado;
          end else begin
            do_adv = 1'b1;
          end
        end
        CONTORNA: begin
          state_d = SEGUE;
          if (head) begin
            do_turn  = 1'b1;
            turn_dir = !lado;
          end else begin
            do_adv = 1'b1;
          end
        end
        default: ;  // TRAVADO ignores passo until reset
      endcase
    end

    if (do_adv) begin
      giros_d = '0;
      if (mov_q != MOV_MAX) mov_d = mov_q + 1'b1;
    end

    // The turn that reaches the limit is still issued; the stall takes effect with it.
    if (do_turn) begin
      giros_d = giros_q + 1'b1;
      if (giros_d == GIROS_LIM) begin
        state_d   = TRAVADO;
        travado_d = 1'b1;
      end
    end

    avancar_d   = do_adv;
    girar_d     = do_turn;
    girar_dir_d = do_turn & turn_dir;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= BUSCA;
      giros_q     <= '0;
      mov_q       <= '0;
      avancar_q   <= 1'b0;
      girar_q     <= 1'b0;
      girar_dir_q <= 1'b0;
      travado_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      giros_q     <= giros_d;
      mov_q       <= mov_d;
      avancar_q   <= avancar_d;
      girar_q     <= girar_d;
      girar_dir_q <= girar_dir_d;
      travado_q   <= travado_d;
    end
  end

  assign avancar    = avancar_q;
  assign girar      = girar_q;
  assign girar_dir  = girar_dir_q;
  assign travado    = travado_q;
  assign estado     = state_q;
  assign movimentos = mov_q;

endmodule

// File: doc/robo_seguidor_param.md
# robo_seguidor_param

Parametrised wall-following controller for the grid robot: the next generation of the `Robo` FSM, driven step by step by the `Robo_TB`-style map bench. It adds:
- selectable follow side (left or right wall), with an explicit turn direction;
- a right-side sensor;
- a step strobe;
- a saturating move counter;
- stuck detection that halts the robot after too many consecutive turns.

## Interface
- `CNT_W`, default 8: width of move counter `movimentos`.
- `MAX_GIROS`, default 4: consecutive turns without an advance that trigger stuck state; legal range 2..15.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `passo`, in, 1: step strobe; one decision per cycle in which `passo`=1.
- `head`, in, 1: obstacle directly ahead.
- `left`, in, 1: obstacle on the left.
- `right`, in, 1: obstacle on the right.
- `lado`, in, 1: follow side; 0 = left wall, 1 = right wall. Sampled with `passo`.
- `avancar`, out, 1: move one cell forward (registered, one-cycle pulse).
- `girar`, out, 1: rotate 90° (registered, one-cycle pulse).
- `girar_dir`, out, 1: turn direction valid with `girar`; 0 = left, 1 = right. Held 0 otherwise.
- `travado`, out, 1: stuck flag, sticky until reset.
- `estado`, out, 2: current state. BUSCA=00, SEGUE=01, CONTORNA=10, TRAVADO=11.
- `movimentos`, out, CNT_W: advances since reset, saturating.

## Operation
Definitions:
- w = `lado` ? `right` : `left` (side-wall sensor).
- "turn toward" = `girar`, `girar_dir`=`lado`.
- "turn away" = `girar`, `girar_dir`=!`lado`.

Each decision issues exactly one action: advance, turn toward, or turn away. Rules per state, applied on `passo`:
- **BUSCA** (no wall acquired yet):
  - `head`=1 → turn away, go to SEGUE.
  - else w=1 → advance, go to SEGUE.
  - else → advance, stay in BUSCA.
- **SEGUE**:
  - w=1, `head`=0 → advance.
  - w=1, `head`=1 → turn away.
  - w=0 → turn toward, go to CONTORNA.
  - SEGUE is otherwise held.
- **CONTORNA** (corner just rounded):
  - `head`=0 → advance, go to SEGUE.
  - `head`=1 → turn away, go to SEGUE.
- **TRAVADO**: `passo` is ignored; no action is issued and the state is held until `reset`.

Turn counter `giros`:
- Width = $clog2(MAX_GIROS+1).
- Cleared on every advance; incremented on every turn.
- If a turn brings `giros` to MAX_GIROS, that turn is still issued. In the same edge the state becomes TRAVADO and `travado` rises.

Move counter `movimentos`:
- +1 on every advance.
- Saturates at 2^CNT_W−1 and never wraps.

## Timing
- **Reset** (synchronous, has priority over `passo`). On the next rising edge:
  - `estado`=BUSCA, `giros`=0, `movimentos`=0;
  - `avancar`=`girar`=`girar_dir`=`travado`=0.
  - Reset during a pending pulse cancels it.
- **Latency**: sensors, `lado` and `passo` are sampled at rising edge k. The action pulse is visible from k until k+1, for exactly one cycle. `estado` and `movimentos` update at the same edge k.
- **Idle**: with `passo`=0, `avancar`=`girar`=`girar_dir`=0, and state and counters hold.
- **Back-to-back** `passo` is legal: one decision per cycle.
- **Mutual exclusion**: `avancar` and `girar` are never both 1.
- **`lado` changes mid-run**: the new value takes effect at the next `passo`; the state is not reset.
- **Bench protocol** (100 ns clock):
  - drive sensors and `passo` at a negedge;
  - read outputs at the following negedge;
  - update the map position, then repeat.

## Test plan
1. **Reset**: hold `reset`=1 with `passo`=1 and `head`=1 for 3 cycles → all outputs 0, `estado`=00. After release and one idle cycle, still all 0.
2. **BUSCA → SEGUE**: `lado`=0.
   - `passo` with h=0, left=0 → `avancar`, `estado`=00.
   - Then h=0, left=1 → `avancar`, `estado`=01.
   - `movimentos`=2.
3. **Right-wall follow and corner**: `lado`=1 in SEGUE.
   - right=1, h=1 → `girar`, `girar_dir`=0.
   - right=0 → `girar`, `girar_dir`=1, `estado`=10.
   - Next h=0 → `avancar`, `estado`=01.
4. **Stuck**: `MAX_GIROS`=4, all sensors=1, 4 steps → four `girar` pulses. The 4th edge sets `travado`=1, `estado`=11. A 5th `passo` gives no pulse. Reset clears the flag.
5. **Saturation**: `CNT_W`=3, 9 advances → `movimentos` goes 1..7, then stays 7.
6. **Turn-counter clear**: `MAX_GIROS`=4, `lado`=0 in SEGUE.
   - Three `girar` pulses: left=1, h=1 → turn away, repeated 3 times.
   - Then one `avancar`: left=1, h=0.
   - Then three more `girar` pulses with left=1, h=1.
   - Required: `travado` stays 0 throughout.
